tlp_sink_mux_rr: RTL and testbench



---
 rtl/tlp_sink_mux_rr.sv | 181 ++++++++++++++++++
 tb/tb_tlp_sink_mux_rr.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_sink_mux_rr.sv
// tlp_sink_mux_rr: N-port TLP transmit arbiter for the 64-bit AXI-stream.
// Grants one port at a time (round-robin or fixed priority). It fetches the
// whole pre-buffered TLP in one transfer, then streams it qword by qword.
// A request timeout, forced termination of overlong TLPs, and TLP/error
// counters are included.
//
// Handshake: a tx beat transfers on a rising clk edge where tx_valid and
// tx_ready are both 1. Once tx_valid is raised, it stays high with
// tx_data/tx_keep/tx_last stable until that beat transfers. tx_valid never
// depends on tx_ready. p_req_data is a one-cycle fetch strobe. The granted
// port answers with a one-cycle p_valid, in the request cycle or later.
module tlp_sink_mux_rr #(
  parameter int NPORT        = 3,
  parameter int MAX_QW       = 18,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arb_rr,
  input  logic [NPORT-1:0]           px_en,
  input  logic [NPORT-1:0]           p_has_data,
  output logic [NPORT-1:0]           p_req_data,
  input  logic [NPORT-1:0]           p_valid,
  input  logic [NPORT*66*MAX_QW-1:0] p_data,
  output logic [63:0]                tx_data,
  output logic [7:0]                 tx_keep,
  output logic                       tx_last,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [15:0]                tlp_count,
  output logic [7:0]                 err_count,
  output logic [1:0]                 dbg_state
);

  localparam int EW = 66;
  localparam int IW = EW * MAX_QW;
  localparam int PW = $clog2(NPORT);
  localparam int BW = $clog2(MAX_QW);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SEND} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    gnt_q, gnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NPORT-1:0] req_q, req_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [IW-1:0]    shreg_q, shreg_d;
  logic [15:0]      tlp_q, tlp_d;
  logic [7:0]       err_q, err_d;

  logic [NPORT-1:0] cand;
  logic [PW:0]      idx;
  logic [PW-1:0]    pick;
  logic             found;
  logic [IW-1:0]    sel_data;
  logic [EW-1:0]    head;
  logic             forced;
  logic             last_c;
  logic             in_send;
  logic [PW-1:0]    next_ptr;

  assign cand     = p_has_data & px_en;
  assign sel_data = p_data[int'(gnt_q)*IW +: IW];
  assign head     = shreg_q[EW-1:0];
  assign forced   = (beat_q == BW'(MAX_QW-1));
  assign last_c   = head[64] | forced;
  assign in_send  = (state_q == S_SEND);
  assign next_ptr = (gnt_q == PW'(NPORT-1)) ? '0 : gnt_q + 1'b1;

  // Grant pick: first candidate at/after the rr pointer (wrapping), or lowest index in fixed mode.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NPORT; i++) begin
      idx = (arb_rr ? {1'b0, ptr_q} : '0) + (PW+1)'(i);
      if (idx >= (PW+1)'(NPORT)) idx = idx - (PW+1)'(NPORT);
      if (!found && cand[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // Next-state and datapath update for the IDLE/REQ/WAIT/SEND sequence.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    req_d   = '0;
    tmo_d   = tmo_q;
    beat_d  = beat_q;
    shreg_d = shreg_q;
    tlp_d   = tlp_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = pick;
          req_d   = NPORT'(1) << pick;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmo_d = '0;
        if (p_valid[gnt_q]) begin
          shreg_d = sel_data;
          beat_d  = '0;
          state_d = S_SEND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (p_valid[gnt_q]) begin
          shreg_d = sel_data;
          beat_d  = '0;
          state_d = S_SEND;
        end else if (tmo_q == 8'(WAIT_TIMEOUT-1)) begin
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          ptr_d   = next_ptr;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          shreg_d = shreg_q >> EW;
          beat_d  = beat_q + 1'b1;
          if (last_c) begin
            tlp_d   = tlp_q + 16'd1;
            if (!head[64]) err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            ptr_d   = next_ptr;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      req_q   <= '0;
      tmo_q   <= '0;
      beat_q  <= '0;
      shreg_q <= '0;
      tlp_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      tmo_q   <= tmo_d;
      beat_q  <= beat_d;
      shreg_q <= shreg_d;
      tlp_q   <= tlp_d;
      err_q   <= err_d;
    end
  end

  // Stream outputs are held at zero outside SEND.
  assign tx_valid   = in_send;
  assign tx_data    = in_send ? head[63:0] : 64'h0;
  assign tx_keep    = in_send ? ((head[64] && !head[65]) ? 8'h0F : 8'hFF) : 8'h00;
  assign tx_last    = in_send & last_c;
  assign p_req_data = req_q;
  assign busy       = (state_q != S_IDLE);
  assign tlp_count  = tlp_q;
  assign err_count  = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tlp_sink_mux_rr.sv
// Directed bench for tlp_sink_mux_rr (NPORT=3, MAX_QW=6, WAIT_TIMEOUT=16).
// All driving and sampling happens on the falling clock edge.
module tb_tlp_sink_mux_rr;
  localparam int NPORT        = 3;
  localparam int MAX_QW       = 6;
  localparam int WAIT_TIMEOUT = 16;
  localparam int EW           = 66;
  localparam int PORT_W       = EW * MAX_QW;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    arb_rr;
  logic [NPORT-1:0]        px_en;
  logic [NPORT-1:0]        p_has_data;
  logic [NPORT-1:0]        p_req_data;
  logic [NPORT-1:0]        p_valid;
  logic [NPORT*PORT_W-1:0] p_data;
  logic [63:0]             tx_data;
  logic [7:0]              tx_keep;
  logic                    tx_last;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    busy;
  logic [15:0]             tlp_count;
  logic [7:0]              err_count;
  logic [1:0]              dbg_state;

  int          checks = 0;
  int          errors = 0;
  int          exp_tlp = 0;
  int          exp_err = 0;
  logic [63:0] base_q [NPORT];

  tlp_sink_mux_rr #(.NPORT(NPORT), .MAX_QW(MAX_QW), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .arb_rr(arb_rr), .px_en(px_en), .p_has_data(p_has_data),
    .p_req_data(p_req_data), .p_valid(p_valid), .p_data(p_data), .tx_data(tx_data),
    .tx_keep(tx_keep), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .tlp_count(tlp_count), .err_count(err_count), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Fill one port image: n entries base+i, optional natural last on entry n-1.
  task automatic load_tlp(input int port, input int n, input logic [63:0] base,
                          input bit nat_last, input bit last_upper);
    logic [65:0] e;
    for (int i = 0; i < MAX_QW; i++) begin
      e = '0;
      if (i < n) begin
        e[63:0] = base + 64'(i);
        e[65]   = 1'b1;
        if (nat_last && i == n-1) begin
          e[64] = 1'b1;
          e[65] = last_upper;
        end
      end
      p_data[port*PORT_W + i*EW +: EW] = e;
    end
    base_q[port] = base;
  endtask

  // Wait (bounded) for a fetch strobe and check it targets exp_port.
  task automatic wait_grant(input string tag, input int exp_port);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (p_req_data != '0) seen = 1'b1;
    end
    chk({tag, "_req_seen"}, 80'(seen), 80'(1));
    if (seen) chk({tag, "_req_port"}, 80'(p_req_data), 80'(3'b001 << exp_port));
  endtask

  // Called at the negedge where p_req_data is high; answers one cycle later.
  task automatic deliver(input string tag, input int port);
    step();
    chk({tag, "_req_pulse"}, 80'(p_req_data), 80'(0));
    p_valid = 3'b001 << port;
    step();
    p_valid = '0;
    chk({tag, "_valid_latency"}, 80'(tx_valid), 80'(1));
  endtask

  // Drain one TLP; stall=1 drives tx_ready 1,0,0,1,0,0,...
  task automatic collect(input string tag, input int port, input int nbeats,
                         input logic [7:0] last_keep, input bit stall);
    int          b;
    int          cyc;
    bit          done;
    bit          held;
    bit          rdy;
    logic [72:0] prev;
    logic [72:0] cur;
    logic [72:0] exp;
    b = 0; cyc = 0; done = 1'b0; held = 1'b0; prev = '0;
    while (!done && cyc < 60) begin
      cur = {tx_last, tx_keep, tx_data};
      chk({tag, "_valid_held"}, 80'(tx_valid), 80'(1));
      if (held) chk({tag, "_stall_stable"}, 80'(cur), 80'(prev));
      rdy = stall ? (cyc % 3 == 0) : 1'b1;
      tx_ready = rdy;
      if (rdy) begin
        exp = {(b == nbeats-1), ((b == nbeats-1) ? last_keep : 8'hFF), base_q[port] + 64'(b)};
        chk($sformatf("%s_beat%0d", tag, b), 80'(cur), 80'(exp));
        b++;
        if (b == nbeats) done = 1'b1;
      end
      prev = cur;
      held = !rdy;
      step();
      cyc++;
    end
    tx_ready = 1'b0;
    chk({tag, "_beats_done"}, 80'(done), 80'(1));
    chk({tag, "_valid_after_last"}, 80'(tx_valid), 80'(0));
    chk({tag, "_busy_after_last"}, 80'(busy), 80'(0));
    chk({tag, "_tlp_count"}, 80'(tlp_count), 80'(exp_tlp));
    chk({tag, "_err_count"}, 80'(err_count), 80'(exp_err));
  endtask

  initial begin
    // reset
    rst_n = 1'b0; arb_rr = 1'b1; px_en = '0; p_has_data = '0; p_valid = '0;
    p_data = '0; tx_ready = 1'b0;
    for (int i = 0; i < NPORT; i++) base_q[i] = '0;
    step(); step(); step();
    chk("rst_tx_valid", 80'(tx_valid), 80'(0));
    chk("rst_tx_out", 80'({tx_last, tx_keep, tx_data}), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_req", 80'(p_req_data), 80'(0));
    chk("rst_tlp_count", 80'(tlp_count), 80'(0));
    chk("rst_err_count", 80'(err_count), 80'(0));

    // round-robin fairness: all ports hold 2-entry TLPs continuously
    load_tlp(0, 2, 64'h1000_0000_0000_0000, 1'b1, 1'b1);
    load_tlp(1, 2, 64'h2000_0000_0000_0000, 1'b1, 1'b1);
    load_tlp(2, 2, 64'h3000_0000_0000_0000, 1'b1, 1'b1);
    px_en = 3'b111; p_has_data = 3'b111; arb_rr = 1'b1;
    rst_n = 1'b1;
    for (int r = 0; r < 6; r++) begin
      wait_grant($sformatf("rr%0d", r), r % 3);
      deliver($sformatf("rr%0d", r), r % 3);
      exp_tlp++;
      collect($sformatf("rr%0d", r), r % 3, 2, 8'hFF, 1'b0);
    end

    // fixed priority: port 0 every time
    arb_rr = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_grant($sformatf("fix%0d", r), 0);
      deliver($sformatf("fix%0d", r), 0);
      exp_tlp++;
      collect($sformatf("fix%0d", r), 0, 2, 8'hFF, 1'b0);
    end

    // single 3-entry TLP on port 1, last entry lower dword only
    arb_rr = 1'b1;
    load_tlp(1, 3, 64'h4A00_0001_0000_0010, 1'b1, 1'b0);
    p_has_data = 3'b010;
    step();
    chk("single_req_latency", 80'(p_req_data), 80'(3'b010));
    p_has_data = '0;
    deliver("single", 1);
    exp_tlp++;
    collect("single", 1, 3, 8'h0F, 1'b0);

    // backpressure on a 5-beat TLP from port 0
    load_tlp(0, 5, 64'h5500_0000_0000_0100, 1'b1, 1'b1);
    p_has_data = 3'b001;
    wait_grant("bp", 0);
    p_has_data = '0;
    deliver("bp", 0);
    exp_tlp++;
    collect("bp", 0, 5, 8'hFF, 1'b1);

    // timeout on port 2; a stray p_valid from port 0 must be ignored
    load_tlp(0, 3, 64'h6600_0000_0000_0200, 1'b1, 1'b1);
    px_en = 3'b100; p_has_data = 3'b111;
    step();
    chk("tmo_req_port", 80'(p_req_data), 80'(3'b100));
    px_en = 3'b111;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 2) p_valid = 3'b001;
      if (i == 10) p_valid = '0;
    end
    chk("tmo_busy_last_wait", 80'(busy), 80'(1));
    chk("tmo_err_before", 80'(err_count), 80'(0));
    step();
    exp_err++;
    chk("tmo_idle", 80'(busy), 80'(0));
    chk("tmo_err_count", 80'(err_count), 80'(exp_err));
    step();
    chk("tmo_next_grant", 80'(p_req_data), 80'(3'b001));
    p_has_data = '0;
    deliver("tmo_p0", 0);
    exp_tlp++;
    collect("tmo_p0", 0, 3, 8'hFF, 1'b0);

    // overlong TLP on port 1: no last flag, forced on beat MAX_QW
    load_tlp(1, 6, 64'h7700_0000_0000_0300, 1'b0, 1'b1);
    p_has_data = 3'b010;
    wait_grant("long", 1);
    p_has_data = '0;
    deliver("long", 1);
    exp_tlp++;
    exp_err++;
    collect("long", 1, 6, 8'hFF, 1'b0);

    // reset after two of five beats
    load_tlp(2, 5, 64'h8800_0000_0000_0400, 1'b1, 1'b1);
    p_has_data = 3'b100;
    wait_grant("rstmid", 2);
    p_has_data = '0;
    deliver("rstmid", 2);
    tx_ready = 1'b1;
    chk("rstmid_beat0", 80'(tx_data), 80'(64'h8800_0000_0000_0400));
    step();
    chk("rstmid_beat1", 80'(tx_data), 80'(64'h8800_0000_0000_0401));
    step();
    rst_n = 1'b0;
    step();
    chk("rstmid_valid", 80'(tx_valid), 80'(0));
    chk("rstmid_busy", 80'(busy), 80'(0));
    chk("rstmid_tlp_count", 80'(tlp_count), 80'(0));
    chk("rstmid_err_count", 80'(err_count), 80'(0));
    chk("rstmid_req", 80'(p_req_data), 80'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rstmid_quiet%0d", i), 80'(tx_valid), 80'(0));
    end
    tx_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
